// File: rtl/output_port_controller.sv
// Memory-mapped actuator output port: level latch, atomic set/clear/toggle,
// per-pin polarity and a retriggerable timed pulse, all behind registered pins.
//
// state  | meaning
// IDLE   | no pulse running, mask and count are zero
// ACTIVE | pulse mask XORed onto pins, count decrementing to terminal count 1
module output_port_controller #(
  parameter int NUM_OUTPUTS = 12,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [1:0]             register_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   done,
  output logic                   busy,
  output logic [NUM_OUTPUTS-1:0] out_data
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state;
  logic                   ctrl_run;
  logic                   ctrl_en;
  logic [NUM_OUTPUTS-1:0] polarity;
  logic [NUM_OUTPUTS-1:0] latch;
  logic [NUM_OUTPUTS-1:0] pulse_mask;
  logic [31:0]            count;

  logic                   wr_ctrl, wr_latch, wr_setclr, wr_pulse;
  logic                   run_next;
  logic [31:0]            pulse_len;
  logic [NUM_OUTPUTS-1:0] set_m, clr_m;
  logic [NUM_OUTPUTS-1:0] tgl_m, only_set, only_clr;
  logic [NUM_OUTPUTS-1:0] next_out;
  logic [11:0]            mask_rd;
  logic [63:0]            rd_full;
  logic                   unused_wr_bits;

  // The 12-bit mask fields map onto pins 0..11; wider ports leave upper pins unreachable.
  if (NUM_OUTPUTS > 12) begin : g_wide
    assign set_m   = {{(NUM_OUTPUTS-12){1'b0}}, wr_data[11:0]};
    assign clr_m   = {{(NUM_OUTPUTS-12){1'b0}}, wr_data[23:12]};
    assign mask_rd = pulse_mask[11:0];
  end else if (NUM_OUTPUTS == 12) begin : g_exact
    assign set_m   = wr_data[11:0];
    assign clr_m   = wr_data[23:12];
    assign mask_rd = pulse_mask;
  end else begin : g_narrow
    assign set_m   = wr_data[NUM_OUTPUTS-1:0];
    assign clr_m   = wr_data[12 +: NUM_OUTPUTS];
    assign mask_rd = {{(12-NUM_OUTPUTS){1'b0}}, pulse_mask};
  end

  assign unused_wr_bits = ^wr_data[DATA_WIDTH-1:44];

  assign wr_ctrl   = we && (register_addr == 2'd0);
  assign wr_latch  = we && (register_addr == 2'd1) && ctrl_run;
  assign wr_setclr = we && (register_addr == 2'd2) && ctrl_run;
  assign wr_pulse  = we && (register_addr == 2'd3) && ctrl_run;
  assign pulse_len = wr_data[43:12];

  // Clearing run takes effect on the same edge as the CONTROL write.
  assign run_next  = wr_ctrl ? wr_data[0] : ctrl_run;

  assign tgl_m    = set_m & clr_m;
  assign only_set = set_m & ~clr_m;
  assign only_clr = clr_m & ~set_m;

  assign next_out = ctrl_en ? ((latch ^ ((state == ACTIVE) ? pulse_mask : '0)) ^ polarity)
                            : '0;
  assign busy     = (state == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ctrl_run   <= 1'b0;
      ctrl_en    <= 1'b0;
      polarity   <= '0;
      latch      <= '0;
      pulse_mask <= '0;
      count      <= '0;
      done       <= 1'b0;
      out_data   <= '0;
    end else begin
      done     <= we;
      out_data <= next_out;

      if (wr_ctrl) begin
        ctrl_run <= wr_data[0];
        ctrl_en  <= wr_data[1];
        polarity <= wr_data[2 +: NUM_OUTPUTS];
      end

      if (!run_next) begin
        latch      <= '0;
        pulse_mask <= '0;
        count      <= '0;
        state      <= IDLE;
      end else begin
        if (wr_latch)
          latch <= wr_data[NUM_OUTPUTS-1:0];
        else if (wr_setclr)
          latch <= ((latch | only_set) & ~only_clr) ^ tgl_m;

        case (state)
          IDLE: begin
            if (wr_pulse && (pulse_len != 32'd0)) begin
              pulse_mask <= set_m;
              count      <= pulse_len;
              state      <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (wr_pulse && (pulse_len != 32'd0)) begin
              pulse_mask <= set_m;
              count      <= pulse_len;
            end else if (count == 32'd1) begin
              pulse_mask <= '0;
              count      <= '0;
              state      <= IDLE;
            end else begin
              count <= count - 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_full = '0;
    case (register_addr)
      2'd0: begin
        rd_full[0]                = ctrl_run;
        rd_full[1]                = ctrl_en;
        rd_full[2 +: NUM_OUTPUTS] = polarity;
      end
      2'd1:    rd_full[NUM_OUTPUTS-1:0] = latch;
      2'd3:    rd_full[43:0]            = {count, mask_rd};
      default: rd_full                  = '0;
    endcase
  end

  assign rd_data = DATA_WIDTH'(rd_full);

endmodule

// File: tb/tb_output_port_controller.sv
// Directed bench for output_port_controller: register access, set/clear,
// pulse timing, retrigger, polarity/enable, soft and hard reset.
module tb_output_port_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  register_addr = 2'd0;
  logic [63:0] wr_data = '0;
  logic [63:0] rd_data;
  logic        done;
  logic        busy;
  logic [11:0] out_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  output_port_controller #(.NUM_OUTPUTS(12), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .register_addr(register_addr),
    .wr_data(wr_data), .rd_data(rd_data), .done(done), .busy(busy),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Drives one write for a single cycle; returns 1ns after the sampling edge.
  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    @(negedge clk);
    we = 1'b1; register_addr = a; wr_data = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    register_addr = a; #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (out_data !== 12'h000) $display("FAIL reset_out got %h exp 000", out_data); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      total_cnt++; if (rd_data !== 64'h0) $display("FAIL reset_rd%0d got %h exp 0", a, rd_data); else pass_cnt++;
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    wr(2'd0, 64'h3);
    total_cnt++; if (done !== 1'b1) $display("FAIL basic_done_ctrl got %b exp 1", done); else pass_cnt++;
    step;
    total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_drop got %b exp 0", done); else pass_cnt++;
    wr(2'd1, 64'hA5A);
    total_cnt++; if (done !== 1'b1) $display("FAIL basic_done_data got %b exp 1", done); else pass_cnt++;
    total_cnt++; if (out_data !== 12'h000) $display("FAIL basic_out_early got %h exp 000", out_data); else pass_cnt++;
    step;
    total_cnt++; if (out_data !== 12'hA5A) $display("FAIL basic_out got %h exp a5a", out_data); else pass_cnt++;
    rd(2'd1);
    total_cnt++; if (rd_data !== 64'hA5A) $display("FAIL basic_rd_latch got %h exp a5a", rd_data); else pass_cnt++;
  endtask

  task automatic test_set_clr;
    wr(2'd1, 64'h00F);
    wr(2'd2, 64'h003_030);
    rd(2'd1);
    total_cnt++; if (rd_data !== 64'h03C) $display("FAIL setclr_1 got %h exp 03c", rd_data); else pass_cnt++;
    wr(2'd2, 64'h001_001);
    rd(2'd1);
    total_cnt++; if (rd_data !== 64'h03D) $display("FAIL setclr_toggle got %h exp 03d", rd_data); else pass_cnt++;
    rd(2'd2);
    total_cnt++; if (rd_data !== 64'h0) $display("FAIL setclr_rd0 got %h exp 0", rd_data); else pass_cnt++;
    step;
    total_cnt++; if (out_data !== 12'h03D) $display("FAIL setclr_out got %h exp 03d", out_data); else pass_cnt++;
  endtask

  task automatic test_pulse;
    logic [9:0] bv, pv;
    wr(2'd1, 64'h0);
    wr(2'd3, 64'h5_100);
    rd(2'd3);
    total_cnt++; if (rd_data !== 64'h5_100) $display("FAIL pulse_rd got %h exp 5100", rd_data); else pass_cnt++;
    bv[0] = busy; pv[0] = out_data[8];
    for (int i = 1; i < 10; i++) begin
      step; bv[i] = busy; pv[i] = out_data[8];
    end
    total_cnt++; if (bv !== 10'h01F) $display("FAIL pulse_busy got %b exp %b", bv, 10'h01F); else pass_cnt++;
    total_cnt++; if (pv !== 10'h03E) $display("FAIL pulse_pin got %b exp %b", pv, 10'h03E); else pass_cnt++;
  endtask

  task automatic test_retrigger;
    logic [11:0] bv, pv;
    wr(2'd3, 64'h5_100);
    bv[0] = busy; pv[0] = out_data[8];
    step; bv[1] = busy; pv[1] = out_data[8];
    step; bv[2] = busy; pv[2] = out_data[8];
    wr(2'd3, 64'h4_100);
    bv[3] = busy; pv[3] = out_data[8];
    for (int i = 4; i < 12; i++) begin
      step; bv[i] = busy; pv[i] = out_data[8];
    end
    total_cnt++; if (bv !== 12'h07F) $display("FAIL retrig_busy got %b exp %b", bv, 12'h07F); else pass_cnt++;
    total_cnt++; if (pv !== 12'h0FE) $display("FAIL retrig_pin got %b exp %b", pv, 12'h0FE); else pass_cnt++;
  endtask

  task automatic test_zero_len;
    wr(2'd3, 64'h0_100);
    total_cnt++; if (busy !== 1'b0) $display("FAIL zero_len_busy got %b exp 0", busy); else pass_cnt++;
    step;
    total_cnt++; if (out_data !== 12'h000) $display("FAIL zero_len_out got %h exp 000", out_data); else pass_cnt++;
  endtask

  task automatic test_polarity;
    wr(2'd1, 64'h0);
    wr(2'd0, 64'h3FFF);
    step;
    total_cnt++; if (out_data !== 12'hFFF) $display("FAIL pol_out got %h exp fff", out_data); else pass_cnt++;
    wr(2'd1, 64'h123);
    step;
    total_cnt++; if (out_data !== 12'hEDC) $display("FAIL pol_latch got %h exp edc", out_data); else pass_cnt++;
    wr(2'd0, 64'h3FFD);
    step;
    total_cnt++; if (out_data !== 12'h000) $display("FAIL en_off_out got %h exp 000", out_data); else pass_cnt++;
    rd(2'd1);
    total_cnt++; if (rd_data !== 64'h123) $display("FAIL en_off_latch got %h exp 123", rd_data); else pass_cnt++;
    rd(2'd0);
    total_cnt++; if (rd_data !== 64'h3FFD) $display("FAIL en_off_ctrl got %h exp 3ffd", rd_data); else pass_cnt++;
  endtask

  task automatic test_run_abort;
    wr(2'd0, 64'h3);
    wr(2'd1, 64'h0);
    wr(2'd3, 64'h64_0F0);
    step;
    total_cnt++; if (busy !== 1'b1) $display("FAIL abort_pre_busy got %b exp 1", busy); else pass_cnt++;
    total_cnt++; if (out_data !== 12'h0F0) $display("FAIL abort_pre_out got %h exp 0f0", out_data); else pass_cnt++;
    wr(2'd0, 64'h2);
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else pass_cnt++;
    rd(2'd3);
    total_cnt++; if (rd_data !== 64'h0) $display("FAIL abort_rd3 got %h exp 0", rd_data); else pass_cnt++;
    step;
    total_cnt++; if (out_data !== 12'h000) $display("FAIL abort_out got %h exp 000", out_data); else pass_cnt++;
    wr(2'd1, 64'h555);
    total_cnt++; if (done !== 1'b1) $display("FAIL softrst_done got %b exp 1", done); else pass_cnt++;
    rd(2'd1);
    total_cnt++; if (rd_data !== 64'h0) $display("FAIL softrst_latch got %h exp 0", rd_data); else pass_cnt++;
    step;
    total_cnt++; if (out_data !== 12'h000) $display("FAIL softrst_out got %h exp 000", out_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    wr(2'd0, 64'h3);
    @(negedge clk); we = 1'b1; register_addr = 2'd2; wr_data = 64'h001;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done0 got %b exp 1", done); else pass_cnt++;
    @(negedge clk); wr_data = 64'h002;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done1 got %b exp 1", done); else pass_cnt++;
    @(negedge clk); wr_data = 64'h004;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done2 got %b exp 1", done); else pass_cnt++;
    we = 1'b0;
    rd(2'd1);
    total_cnt++; if (rd_data !== 64'h007) $display("FAIL b2b_latch got %h exp 007", rd_data); else pass_cnt++;
    step;
    total_cnt++; if (done !== 1'b0) $display("FAIL b2b_done_end got %b exp 0", done); else pass_cnt++;
  endtask

  task automatic test_max_len;
    wr(2'd1, 64'h0);
    wr(2'd3, 64'h0000_0FFF_FFFF_F001);
    repeat (3) step;
    rd(2'd3);
    total_cnt++; if (rd_data !== 64'h0000_0FFF_FFFF_C001) $display("FAIL maxlen_rd got %h exp 00000ffffffffc001", rd_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL maxlen_busy got %b exp 1", busy); else pass_cnt++;
    total_cnt++; if (out_data !== 12'h001) $display("FAIL maxlen_out got %h exp 001", out_data); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL hrst_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (out_data !== 12'h000) $display("FAIL hrst_out got %h exp 000", out_data); else pass_cnt++;
    rd(2'd0);
    total_cnt++; if (rd_data !== 64'h0) $display("FAIL hrst_ctrl got %h exp 0", rd_data); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    step;
    total_cnt++; if (out_data !== 12'h000) $display("FAIL hrst_after got %h exp 000", out_data); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_set_clr;
    test_pulse;
    test_retrigger;
    test_zero_len;
    test_polarity;
    test_run_abort;
    test_back_to_back;
    test_max_len;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/output_port_controller.md
# output_port_controller

Memory-mapped output port that drives up to NUM_OUTPUTS robot actuator pins (motor enables, LEDs, solenoids) from the HPS bus. It is the write-side counterpart of the input controller and uses the same register-access handshake (we / register_addr / wr_data / rd_data / done). It provides a level latch, atomic set/clear/toggle, per-pin polarity and a retriggerable timed pulse generator, all behind registered, glitch-free pin outputs.

## Interface
- NUM_OUTPUTS, 12, number of driven pins (1..16)
- DATA_WIDTH, 64, bus data width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write strobe, one access per high cycle
- register_addr  in  2  register select
- wr_data  in  DATA_WIDTH  write data
- rd_data  out  DATA_WIDTH  read data, combinational from register_addr
- done  out  1  one-cycle write acknowledge
- busy  out  1  pulse generator active
- out_data  out  NUM_OUTPUTS  registered pin outputs

## Operation
- Register map (unused bits write-ignored, read 0):
  - addr 0 CONTROL, reset 0: bit0 run (0 = soft reset), bit1 enable, bits[2+NUM_OUTPUTS-1:2] polarity invert per pin.
  - addr 1 DATA: bits[NUM_OUTPUTS-1:0] output latch. A write replaces the latch. A read returns the latch.
  - addr 2 SET_CLR: write bits[11:0] set mask, bits[23:12] clear mask. Set and clear on the same bit toggle it. Reads return 0.
  - addr 3 PULSE: write bits[11:0] pin mask, bits[43:12] length L (32-bit cycles). A read returns {20'b0, remaining[31:0], active_mask[11:0]}.
- Soft reset: while CONTROL.run = 0:
  - Latch, pulse mask, counter and busy are held at 0.
  - Writes to addr 1–3 are discarded; done still pulses.
  - CONTROL is always writable.
- Pulse FSM, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on a PULSE write with L != 0: load count = L and mask.
  - A PULSE write with L = 0 is ignored. A write in IDLE has no effect; a write in ACTIVE leaves the running pulse untouched.
  - ACTIVE: count decrements each edge; ACTIVE -> IDLE on the edge where count == 1, and mask clears.
  - A PULSE write in ACTIVE with L != 0 retriggers: it reloads mask and count, no gap.
  - Clearing CONTROL.run aborts the pulse: -> IDLE, count 0.
- Pin value: next_out = enable ? ((latch ^ (ACTIVE ? mask : 0)) ^ polarity) : 0.
  - enable = 0 forces all pins low, including inverted ones. Latch and pulse state are retained and keep counting.
- DATA or SET_CLR writes during a pulse update the latch. The pulse XOR continues to apply on top.
- busy = (state == ACTIVE).

## Timing
- Reset (rst_n low, asynchronous): out_data = 0, done = 0, busy = 0, rd_data reads all registers as 0.
- A write sampled at rising edge N:
  - The register updates at N.
  - done is high from N to N+1, for exactly one cycle per write cycle.
  - out_data reflects the write after edge N+1 (one pipeline register).
- Back-to-back writes (we high on consecutive cycles) are all accepted; done stays high each following cycle.
- Pulse of length L written at edge N: busy is high from N to N+L; the affected pins on out_data are inverted from N+1 to N+L+1, i.e. exactly L cycles.
- rd_data changes in the same cycle as register_addr. It reflects register state after the most recent edge.
- The counter never wraps. L = 0xFFFFFFFF is valid and counts fully.

## Test plan
- Reset, then write CONTROL = 0x3 and DATA = 0xA5A -> done pulses once per write; out_data = 0xA5A one cycle after the DATA write; rd_data at addr 1 = 0xA5A.
- With latch 0x00F, write SET_CLR with set = 0x030 and clear = 0x003 -> latch = 0x03C. Then write set = clear = 0x001 -> latch = 0x03D.
- Write PULSE with mask = 0x100 and L = 5 -> busy high for 5 cycles; out_data[8] high for exactly 5 cycles, then back to 0.
- Retrigger at cycle 3 of an L = 5 pulse with L = 4 -> busy high for 7 cycles total with no gap. PULSE with L = 0 -> busy stays 0.
- Write CONTROL polarity = 0xFFF with enable = 1 and latch 0 -> out_data = 0xFFF. Then enable = 0 -> out_data = 0, and rd_data still shows the latch.
- Clear CONTROL.run mid-pulse, or assert rst_n low mid-pulse -> busy = 0 and out_data = 0 next cycle. With run = 0, a DATA write is ignored but done still pulses.
